// File: rtl/pixel_dither_stream.sv
// rtl/pixel_dither_stream.sv - streaming colour-depth reducer (truncate/round/Bayer/error diffusion)
module pixel_dither_stream #(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 4,
    parameter int CHANNELS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*IN_W-1:0]  in_data,
    input  logic                      in_sof,
    input  logic                      in_eol,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*OUT_W-1:0] out_data,
    output logic                      out_sof,
    output logic                      out_eol
);
    localparam int D = IN_W - OUT_W;
    localparam logic [IN_W-1:0] MAX = '1;

    logic [1:0]              mode_q;
    logic [1:0]              x_q;
    logic [1:0]              y_q;
    logic [CHANNELS*D-1:0]   err_q;

    logic                    accept;
    logic [1:0]              mode_eff;
    logic [1:0]              x_eff;
    logic [1:0]              y_eff;
    logic [CHANNELS*D-1:0]   err_eff;
    logic [3:0]              bay;
    logic [D-1:0]            off;
    logic [IN_W-1:0]         in_ch;
    logic [IN_W:0]           addend;
    logic [IN_W:0]           sum;
    logic [IN_W-1:0]         sat;
    logic [CHANNELS*OUT_W-1:0] pix_nxt;
    logic [CHANNELS*D-1:0]   err_nxt;

    function automatic logic [3:0] bayer(input logic [1:0] yy, input logic [1:0] xx);
        logic [3:0] v;
        case ({yy, xx})
            4'h0: v = 4'd0;   4'h1: v = 4'd8;   4'h2: v = 4'd2;   4'h3: v = 4'd10;
            4'h4: v = 4'd12;  4'h5: v = 4'd4;   4'h6: v = 4'd14;  4'h7: v = 4'd6;
            4'h8: v = 4'd3;   4'h9: v = 4'd11;  4'hA: v = 4'd1;   4'hB: v = 4'd9;
            4'hC: v = 4'd15;  4'hD: v = 4'd7;   4'hE: v = 4'd13;  default: v = 4'd5;
        endcase
        return v;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        mode_eff = in_sof ? mode : mode_q;
        x_eff    = in_sof ? 2'd0 : x_q;
        y_eff    = in_sof ? 2'd0 : y_q;
        err_eff  = in_sof ? '0 : err_q;
        bay      = bayer(y_eff, x_eff);
        // Scaling the 4-bit threshold to D bits works for D above or below 4.
        off      = D'({bay, {D{1'b0}}} >> 4);
        in_ch    = '0;
        addend   = '0;
        sum      = '0;
        sat      = '0;
        pix_nxt  = '0;
        err_nxt  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            in_ch = in_data[k*IN_W +: IN_W];
            case (mode_eff)
                2'd0:    addend = '0;
                2'd1:    addend = (IN_W+1)'(1) << (D-1);
                2'd2:    addend = (IN_W+1)'(off);
                default: addend = (IN_W+1)'(err_eff[k*D +: D]);
            endcase
            sum = {1'b0, in_ch} + addend;
            sat = sum[IN_W] ? MAX : sum[IN_W-1:0];
            pix_nxt[k*OUT_W +: OUT_W] = sat[IN_W-1:D];
            err_nxt[k*D +: D]         = sat[D-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 2'd0;
            x_q    <= 2'd0;
            y_q    <= 2'd0;
            err_q  <= '0;
        end else if (accept) begin
            mode_q <= mode_eff;
            if (in_eol) begin
                x_q   <= 2'd0;
                y_q   <= y_eff + 2'd1;
                err_q <= '0;
            end else begin
                x_q   <= x_eff + 2'd1;
                y_q   <= y_eff;
                err_q <= (mode_eff == 2'd3) ? err_nxt : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= pix_nxt;
            out_sof   <= in_sof;
            out_eol   <= in_eol;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pixel_dither_stream.sv
// tb/tb_pixel_dither_stream.sv - directed table-driven bench for pixel_dither_stream
module tb_pixel_dither_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = '0;
    logic        in_sof = 1'b0;
    logic        in_eol = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_data;
    logic        out_sof;
    logic        out_eol;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pixel_dither_stream #(.IN_W(8), .OUT_W(4), .CHANNELS(3)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sof(in_sof), .in_eol(in_eol),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol)
    );

    typedef struct {
        logic [23:0] data;
        logic        sof;
        logic        eol;
        logic [1:0]  mode;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [23:0] d, input logic s, input logic e,
                       input logic [1:0] m, input logic [11:0] x);
        vec_t v;
        v.data = d; v.sof = s; v.eol = e; v.mode = m; v.exp = x;
        vecs.push_back(v);
    endtask

    logic [23:0] bp_pix [6];
    logic [11:0] bp_exp [6];

    initial begin
        // truncate
        add(24'hAB3FFF, 1, 0, 2'd0, 12'hA3F);
        add(24'h000F10, 0, 0, 2'd0, 12'h001);
        // round with saturation in channel 2
        add(24'hFC7877, 1, 0, 2'd1, 12'hF87);
        // ordered, rows 0 and 1
        add(24'h484848, 1, 0, 2'd2, 12'h444);
        add(24'h484848, 0, 0, 2'd2, 12'h555);
        add(24'h484848, 0, 0, 2'd2, 12'h444);
        add(24'h484848, 0, 1, 2'd2, 12'h555);
        add(24'h484848, 0, 0, 2'd2, 12'h555);
        add(24'h484848, 0, 0, 2'd2, 12'h444);
        add(24'h484848, 0, 0, 2'd2, 12'h555);
        add(24'h484848, 0, 1, 2'd2, 12'h444);
        // error diffusion, restart after eol, saturation at 0xFF
        add(24'h484848, 1, 0, 2'd3, 12'h444);
        add(24'h484848, 0, 0, 2'd3, 12'h555);
        add(24'h484848, 0, 0, 2'd3, 12'h444);
        add(24'h484848, 0, 1, 2'd3, 12'h555);
        add(24'h484848, 0, 0, 2'd3, 12'h444);
        add(24'hFFFFFF, 0, 0, 2'd3, 12'hFFF);
        add(24'hFFFFFF, 0, 0, 2'd3, 12'hFFF);
        // mode input changes without sof: carried error 0xF still applied
        add(24'h484848, 0, 0, 2'd0, 12'h555);
        add(24'h484848, 1, 0, 2'd0, 12'h444);
        // sof and eol together: pixel at (0,0), next at (0,1)
        add(24'h484848, 1, 1, 2'd2, 12'h444);
        add(24'h484848, 0, 0, 2'd2, 12'h555);

        bp_pix = '{24'h484848, 24'h484848, 24'h484848, 24'h373737, 24'h292929, 24'h484848};
        bp_exp = '{12'h444, 12'h555, 12'h444, 12'h333, 12'h333, 12'h555};

        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", {20'd0, out_data}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = vecs[i].data;
            in_sof   = vecs[i].sof;
            in_eol   = vecs[i].eol;
            mode     = vecs[i].mode;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d_data", i), {20'd0, out_data}, {20'd0, vecs[i].exp});
            check($sformatf("vec%0d_sof", i), {31'd0, out_sof}, {31'd0, vecs[i].sof});
            check($sformatf("vec%0d_eol", i), {31'd0, out_eol}, {31'd0, vecs[i].eol});
        end
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
        @(negedge clk);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);

        // backpressure: out_ready low for cycles 3..5
        begin
            int nin = 0;
            int nout = 0;
            logic [11:0] held = '0;
            for (int c = 0; c < 40 && nout < 6; c++) begin
                logic acc;
                out_ready = !(c >= 3 && c <= 5);
                in_valid  = (nin < 6);
                in_data   = bp_pix[nin % 6];
                in_sof    = (nin == 0);
                in_eol    = 1'b0;
                mode      = 2'd3;
                #1;
                if (c == 3) held = out_data;
                if (c >= 3 && c <= 5) begin
                    check($sformatf("bp_in_ready_c%0d", c), {31'd0, in_ready}, 32'd0);
                    check($sformatf("bp_hold_c%0d", c), {20'd0, out_data}, {20'd0, held});
                    check($sformatf("bp_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
                end
                if (out_valid && out_ready) begin
                    check($sformatf("bp_out%0d", nout), {20'd0, out_data}, {20'd0, bp_exp[nout]});
                    nout++;
                end
                acc = in_valid && in_ready;
                @(posedge clk);
                if (acc) nin++;
                @(negedge clk);
            end
            check("bp_all_outputs", nout, 6);
            in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        end

        // reset mid-line in mode 3
        @(negedge clk);
        in_valid = 1'b1; in_data = 24'h484848; in_sof = 1'b1; mode = 2'd3;
        @(negedge clk);
        in_sof = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {20'd0, out_data}, 32'd0);
        check("rst_out_sof_eol", {30'd0, out_sof, out_eol}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        // no sof after reset: mode input ignored, mode_q reset to truncate
        in_valid = 1'b1; in_data = 24'h4F4F4F; in_sof = 1'b0; mode = 2'd2;
        @(posedge clk);
        #1;
        check("post_reset_data", {20'd0, out_data}, 32'h444);
        @(negedge clk);
        in_data = 24'h4F4F4F;
        @(posedge clk);
        #1;
        check("post_reset_data2", {20'd0, out_data}, 32'h444);
        @(negedge clk);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
